// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-style datapath.
// Outputs decode from the current state; only IEXEC/IWB and BRANCH also look at Opcode/Zero.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       PCWrite,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       ExtZero,
    output logic [1:0] PCSource,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD = 4'd3,
        MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB   = 4'd7,
        BRANCH = 4'd8,  IEXEC  = 4'd9,  IWB    = 4'd10, JUMP  = 4'd11,
        JAL    = 4'd12, JR     = 4'd13
    } state_t;

    state_t state_q, state_d;

    logic [2:0] imm_aluop;
    logic       imm_ext;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= FETCH;
        else        state_q <= state_d;
    end

    // Immediate-class ALU op; Opcode is stable through IEXEC and IWB.
    always_comb begin
        imm_aluop = 3'b100;
        imm_ext   = 1'b0;
        case (Opcode)
            6'h0C: begin imm_aluop = 3'b110; imm_ext = 1'b1; end
            6'h0D: begin imm_aluop = 3'b101; imm_ext = 1'b1; end
            6'h0F: imm_aluop = 3'b011;
            default: ;
        endcase
    end

    always_comb begin
        state_d  = FETCH;
        PCWrite  = 1'b0;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 2'b00;
        MemtoReg = 2'b00;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 3'b000;
        ExtZero  = 1'b0;
        PCSource = 2'b00;
        case (state_q)
            FETCH: begin
                IRWrite = 1'b1;
                PCWrite = 1'b1;
                ALUSrcB = 2'b01;
                ALUOp   = 3'b100;
                state_d = DECODE;
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b100;
                case (Opcode)
                    6'h23, 6'h2B:               state_d = MEMADR;
                    6'h00:                      state_d = (Funct == 6'h08) ? JR : REXEC;
                    6'h04, 6'h05:               state_d = BRANCH;
                    6'h08, 6'h0C, 6'h0D, 6'h0F: state_d = IEXEC;
                    6'h02:                      state_d = JUMP;
                    6'h03:                      state_d = JAL;
                    default:                    state_d = FETCH;
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 3'b100;
                state_d = (Opcode == 6'h23) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                IorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 3'b111;
                state_d = RWB;
            end
            RWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            BRANCH: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 3'b001;
                PCSource = 2'b01;
                PCWrite  = ((Opcode == 6'h04) && Zero) || ((Opcode == 6'h05) && !Zero);
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = imm_aluop;
                ExtZero = imm_ext;
                state_d = IWB;
            end
            IWB: begin
                ALUSrcA  = 1'b1;
                ALUSrcB  = 2'b10;
                ALUOp    = imm_aluop;
                ExtZero  = imm_ext;
                RegWrite = 1'b1;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
            end
            JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            default: state_d = FETCH;
        endcase
        // Reset already forces FETCH; suppress its write enables while held.
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized scoreboard bench for multicycle_control: per-instruction expected
// control-vector sequences are queued by the stimulus and checked by a negedge monitor.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw;
        logic       iord;
        logic       memw;
        logic       irw;
        logic [1:0] regdst;
        logic [1:0] m2r;
        logic       regw;
        logic       srca;
        logic [1:0] srcb;
        logic [2:0] aluop;
        logic       extz;
        logic [1:0] pcsrc;
    } ctl_t;

    logic       clk, reset, Zero;
    logic [5:0] Opcode, Funct;
    logic       PCWrite, IorD, MemWrite, IRWrite, RegWrite, ALUSrcA, ExtZero;
    logic [1:0] RegDst, MemtoReg, ALUSrcB, PCSource;
    logic [2:0] ALUOp;
    logic [3:0] State;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;
    ctl_t exp_q[$];

    multicycle_control dut (
        .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
        .PCWrite(PCWrite), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ExtZero(ExtZero), .PCSource(PCSource),
        .State(State)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    function automatic ctl_t v(input int st, pcw, iord, memw, irw, regdst, m2r, regw,
                               srca, srcb, aluop, extz, pcsrc);
        ctl_t c;
        c.st = st[3:0]; c.pcw = pcw[0]; c.iord = iord[0]; c.memw = memw[0]; c.irw = irw[0];
        c.regdst = regdst[1:0]; c.m2r = m2r[1:0]; c.regw = regw[0]; c.srca = srca[0];
        c.srcb = srcb[1:0]; c.aluop = aluop[2:0]; c.extz = extz[0]; c.pcsrc = pcsrc[1:0];
        return c;
    endfunction

    function automatic ctl_t dut_vec();
        ctl_t c;
        c.st = State; c.pcw = PCWrite; c.iord = IorD; c.memw = MemWrite; c.irw = IRWrite;
        c.regdst = RegDst; c.m2r = MemtoReg; c.regw = RegWrite; c.srca = ALUSrcA;
        c.srcb = ALUSrcB; c.aluop = ALUOp; c.extz = ExtZero; c.pcsrc = PCSource;
        return c;
    endfunction

    task automatic check(input string name, input ctl_t act, input ctl_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_legal(input logic [5:0] op);
        case (op)
            6'h23, 6'h2B, 6'h00, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h02, 6'h03: return 1;
            default: return 0;
        endcase
    endfunction

    // Reference model: the architectural step sequence of one instruction.
    task automatic push_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int alu, ext;
        exp_q.push_back(v(0, 1,0,0,1, 0,0,0, 0,1,4,0,0));
        exp_q.push_back(v(1, 0,0,0,0, 0,0,0, 0,3,4,0,0));
        case (op)
            6'h23: begin
                exp_q.push_back(v(2, 0,0,0,0, 0,0,0, 1,2,4,0,0));
                exp_q.push_back(v(3, 0,1,0,0, 0,0,0, 0,0,0,0,0));
                exp_q.push_back(v(4, 0,0,0,0, 0,1,1, 0,0,0,0,0));
            end
            6'h2B: begin
                exp_q.push_back(v(2, 0,0,0,0, 0,0,0, 1,2,4,0,0));
                exp_q.push_back(v(5, 0,1,1,0, 0,0,0, 0,0,0,0,0));
            end
            6'h00: begin
                if (fn == 6'h08)
                    exp_q.push_back(v(13, 1,0,0,0, 0,0,0, 0,0,0,0,3));
                else begin
                    exp_q.push_back(v(6, 0,0,0,0, 0,0,0, 1,0,7,0,0));
                    exp_q.push_back(v(7, 0,0,0,0, 1,0,1, 0,0,0,0,0));
                end
            end
            6'h04, 6'h05: begin
                int taken;
                taken = ((op == 6'h04) == (z == 1'b1)) ? 1 : 0;
                exp_q.push_back(v(8, taken,0,0,0, 0,0,0, 1,0,1,0,1));
            end
            6'h08, 6'h0C, 6'h0D, 6'h0F: begin
                alu = (op == 6'h08) ? 4 : (op == 6'h0C) ? 6 : (op == 6'h0D) ? 5 : 3;
                ext = (op == 6'h0C || op == 6'h0D) ? 1 : 0;
                exp_q.push_back(v(9,  0,0,0,0, 0,0,0, 1,2,alu,ext,0));
                exp_q.push_back(v(10, 0,0,0,0, 0,0,1, 1,2,alu,ext,0));
            end
            6'h02: exp_q.push_back(v(11, 1,0,0,0, 0,0,0, 0,0,0,0,2));
            6'h03: exp_q.push_back(v(12, 1,0,0,0, 2,2,1, 0,0,0,0,2));
            default: ;
        endcase
    endtask

    // Drive one instruction for exactly as many cycles as the model says it takes.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z);
        int n;
        Opcode = op; Funct = fn; Zero = z;
        n = exp_q.size();
        push_instr(op, fn, z);
        n = exp_q.size() - n;
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL monitor unexpected cycle state=%0d", State);
            end else begin
                check("cycle", dut_vec(), exp_q.pop_front());
            end
        end
    end

    initial begin
        ctl_t rst_vec;
        logic [5:0] op, fn;
        rst_vec = v(0, 0,0,0,0, 0,0,0, 0,1,4,0,0);
        reset = 0; Opcode = 6'h23; Funct = 6'h00; Zero = 0;
        @(negedge clk);
        check("reset_hold", dut_vec(), rst_vec);
        @(posedge clk);
        #1;
        check("reset_hold_edge", dut_vec(), rst_vec);
        reset = 1;
        mon_en = 1;

        run_instr(6'h23, 6'h00, 1'b0);
        run_instr(6'h04, 6'h00, 1'b1);
        run_instr(6'h05, 6'h00, 1'b1);
        run_instr(6'h0D, 6'h00, 1'b0);
        run_instr(6'h0F, 6'h00, 1'b1);
        run_instr(6'h00, 6'h08, 1'b0);
        run_instr(6'h00, 6'h20, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0);
        run_instr(6'h03, 6'h00, 1'b0);
        run_instr(6'h02, 6'h00, 1'b1);
        run_instr(6'h2B, 6'h00, 1'b0);
        run_instr(6'h0C, 6'h00, 1'b0);
        run_instr(6'h08, 6'h00, 1'b1);

        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (is_legal(op));
            end else begin
                case ($urandom_range(0, 10))
                    0: op = 6'h23;  1: op = 6'h2B;  2: op = 6'h00;  3: op = 6'h04;
                    4: op = 6'h05;  5: op = 6'h08;  6: op = 6'h0C;  7: op = 6'h0D;
                    8: op = 6'h0F;  9: op = 6'h02;  default: op = 6'h03;
                endcase
            end
            fn = ($urandom_range(0, 2) == 0) ? 6'h08 : 6'($urandom_range(0, 63));
            run_instr(op, fn, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a store.
        mon_en = 0;
        Opcode = 6'h2B; Funct = 6'h00; Zero = 0;
        repeat (3) @(posedge clk);
        #2;
        check("memwr_reached", dut_vec(), v(5, 0,1,1,0, 0,0,0, 0,0,0,0,0));
        reset = 0;
        #1;
        check("async_reset", dut_vec(), rst_vec);
        @(negedge clk);
        check("async_reset_hold", dut_vec(), rst_vec);
        @(posedge clk);
        #1;
        reset = 1;
        mon_en = 1;
        run_instr(6'h23, 6'h00, 1'b0);
        run_instr(6'h3F, 6'h00, 1'b0);

        mon_en = 0;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL leftover_expected got %0d entries required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 No parameters.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Opcode  input  6  instruction[31:26] from external instruction register; stable from DECODE until return to FETCH.
REQ-005 Funct  input  6  instruction[5:0]; used only to detect JR (6'h08).
REQ-006 Zero  input  1  ALU zero flag; sampled in BRANCH.
REQ-007 PCWrite  output  1  PC load enable.
REQ-008 IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-009 MemWrite  output  1  data memory write enable.
REQ-010 IRWrite  output  1  instruction register load enable.
REQ-011 RegDst  output  2  write register: 00 = rt, 01 = rd, 10 = r31.
REQ-012 MemtoReg  output  2  write data: 00 = ALUOut, 01 = MDR, 10 = PC.
REQ-013 RegWrite  output  1  register file write enable.
REQ-014 ALUSrcA  output  1  0 = PC, 1 = register A.
REQ-015 ALUSrcB  output  2  00 = B, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2.
REQ-016 ALUOp  output  3  ALU control class: 111 = R-type (funct decoded downstream), 100 = add, 001 = sub, 101 = or, 110 = and, 011 = lui.
REQ-017 ExtZero  output  1  1 = zero-extend immediate, 0 = sign-extend.
REQ-018 PCSource  output  2  00 = ALU result, 01 = ALUOut, 10 = jump address, 11 = register A.
REQ-019 State  output  4  current state encoding, for debug and verification.

Function
REQ-020 The block SHALL be a Moore FSM with a 4-bit state register; outputs SHALL be decoded from state, plus Opcode in IEXEC and Zero/Opcode in BRANCH.
REQ-021 States and encodings SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, IEXEC=9, IWB=10, JUMP=11, JAL=12, JR=13.
REQ-022 Outputs not listed for a state SHALL be 0.
REQ-023 FETCH: IRWrite=1, PCWrite=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=100, PCSource=00; next DECODE.
REQ-024 DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=100; next by Opcode: 6'h23/6'h2B->MEMADR, 6'h00 with Funct=6'h08->JR, other 6'h00->REXEC, 6'h04/6'h05->BRANCH, 6'h08/6'h0C/6'h0D/6'h0F->IEXEC, 6'h02->JUMP, 6'h03->JAL, any other->FETCH (no writes).
REQ-025 MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=100; next MEMRD if Opcode=6'h23, else MEMWR.
REQ-026 MEMRD: IorD=1; next MEMWB. MEMWB: RegDst=00, MemtoReg=01, RegWrite=1; next FETCH.
REQ-027 MEMWR: IorD=1, MemWrite=1; next FETCH.
REQ-028 REXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=111; next RWB. RWB: RegDst=01, MemtoReg=00, RegWrite=1; next FETCH.
REQ-029 BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSource=01; PCWrite=1 iff (Opcode=6'h04 and Zero=1) or (Opcode=6'h05 and Zero=0); next FETCH.
REQ-030 IEXEC: ALUSrcA=1, ALUSrcB=10; ALUOp = 100 (ADDI), 110 (ANDI), 101 (ORI), 011 (LUI); ExtZero=1 for ANDI/ORI, else 0; next IWB.
REQ-031 IWB: ALUSrcA, ALUSrcB, ALUOp, ExtZero held at IEXEC values; RegDst=00, MemtoReg=00, RegWrite=1; next FETCH.
REQ-032 JUMP: PCSource=10, PCWrite=1; next FETCH. JAL: PCSource=10, PCWrite=1, RegWrite=1, RegDst=10, MemtoReg=10 (PC already PC+4); next FETCH. JR: PCSource=11, PCWrite=1; next FETCH.
REQ-033 Latency in cycles, FETCH inclusive: LW 5; SW, R-type, I-type 4; branch, J, JAL, JR 3; illegal opcode 2.
REQ-034 Unused state encodings 14 and 15 SHALL transition to FETCH with all outputs 0.

Reset
REQ-035 Asserting reset SHALL force state to FETCH immediately, regardless of clk or current state, including mid-instruction.
REQ-036 While reset is low, PCWrite, IRWrite, MemWrite and RegWrite SHALL be 0; other outputs SHALL take FETCH values.
REQ-037 The first rising clk edge after reset deassertion SHALL execute FETCH.

Verification
REQ-038 LW (Opcode 6'h23) after reset -> State 0,1,2,3,4,0; RegWrite=1 with MemtoReg=01 only in state 4.
REQ-039 BEQ with Zero=1, then BNE with Zero=1 -> PCWrite=1 in BRANCH for BEQ, 0 for BNE; ALUOp=001 both times.
REQ-040 ORI (6'h0D) -> IEXEC ALUOp=101, ExtZero=1; IWB RegDst=00, RegWrite=1; LUI -> ALUOp=011, ExtZero=0.
REQ-041 R-type with Funct=6'h08 -> DECODE->JR, PCSource=11, PCWrite=1, RegWrite never 1; Funct=6'h20 -> REXEC with ALUOp=111, then RWB with RegDst=01.
REQ-042 Opcode 6'h3F -> DECODE->FETCH, no write enable asserted; JAL -> RegDst=10, MemtoReg=10, RegWrite=1, PCWrite=1 in one cycle.
REQ-043 Reset pulsed low asynchronously while in MEMWR -> State=0 and MemWrite=0 before the next clk edge.
